bit_serial_adder: RTL and testbench

Sequential N-bit adder that computes A + B + Cin one bit per clock, LSB first, using a single one-bit full-add cell. It is the addition counterpart to the ALU's one-bit subtractor path, for area-constrained adder/subtractor datapaths. Operands are captured on a Start pulse. The result and carry-out are presented with a one-cycle Done strobe and then held.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/full_adder_bit.sv | 22 ++
 rtl/bit_serial_adder.sv | 141 ++++++++++++++
 tb/tb_bit_serial_adder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the serial ALU datapath cells.
//   - state_e       : FSM encoding for the bit-serial sequencers
//   - DEF_WIDTH     : default operand width
//   - cnt_width()   : width of a bit counter that indexes 0..w-1
// ----------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEF_WIDTH = 8;

   // A counter for 0..w-1 needs clog2(w) bits; keep at least one bit so a
   // degenerate width still yields a legal vector.
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_adder_bit.sv
// ----------------------------------------------------------------------------
// full_adder_bit
//   Combinational one-bit full adder; the adding dual of the one-bit
//   subtractor cell.
//   Ports:
//     A, B  : operand bits
//     C     : carry in
//     Sum   : A ^ B ^ C
//     Cout  : majority(A, B, C)
// ----------------------------------------------------------------------------
module full_adder_bit (
   input  logic A,
   input  logic B,
   input  logic C,
   output logic Sum,
   output logic Cout
);

   assign Sum  = A ^ B ^ C;
   assign Cout = (A & B) | (A & C) | (B & C);

endmodule

// File: rtl/bit_serial_adder.sv
// ----------------------------------------------------------------------------
// bit_serial_adder
//   Computes A + B + Cin one bit per clock, LSB first, through a single
//   full_adder_bit cell. Operands are captured on an accepted Start; the
//   result is presented with a one-cycle Done strobe and then held.
//
//   Parameters:
//     WIDTH : operand / result width (>= 2)
//   Ports:
//     CLK   : rising-edge clock
//     RST_N : asynchronous active-low reset
//     Start : request, honoured only in IDLE or DONE
//     A, B  : operands, captured on accepted Start
//     Cin   : carry in, captured on accepted Start
//     Busy  : high while bits are being processed
//     Done  : one-cycle strobe when a new result is valid
//     Sum   : result of the last completed operation
//     Cout  : final carry of the last completed operation
//     Ovf   : signed overflow of the last completed operation
//             (present only when BIT_SERIAL_ADDER_OVF_EN is defined)
//
//   Latency: Start sampled at edge k -> Done/Sum/Cout valid after edge
//   k+WIDTH. Back-to-back Start in DONE gives one result per WIDTH+1 cycles.
// ----------------------------------------------------------------------------
import alu_pkg::*;

module bit_serial_adder #(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
`ifdef BIT_SERIAL_ADDER_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] psum;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             fa_sum;
   logic             fa_cout;

   // Single adder cell, fed from the operand LSBs and the carry flop.
   full_adder_bit u_fa (
      .A    (a_sr[0]),
      .B    (b_sr[0]),
      .C    (carry),
      .Sum  (fa_sum),
      .Cout (fa_cout)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         psum  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         Busy  <= 1'b0;
         Done  <= 1'b0;
         Sum   <= '0;
         Cout  <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
         Ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               Done <= 1'b0;
               if (Start) begin
                  a_sr  <= A;
                  b_sr  <= B;
                  carry <= Cin;
                  cnt   <= '0;
                  Busy  <= 1'b1;
                  state <= RUN;
               end
            end

            RUN: begin
               // Sum bits enter at the MSB so after WIDTH shifts the first
               // (LSB) result bit has landed in bit 0.
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               psum  <= {fa_sum, psum[WIDTH-1:1]};
               carry <= fa_cout;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  Sum   <= {fa_sum, psum[WIDTH-1:1]};
                  Cout  <= fa_cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
                  // carry flop holds the carry into the MSB at this point
                  Ovf   <= carry ^ fa_cout;
`endif
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
                  state <= DONE;
               end
            end

            DONE: begin
               Done <= 1'b0;
               if (Start) begin
                  a_sr  <= A;
                  b_sr  <= B;
                  carry <= Cin;
                  cnt   <= '0;
                  Busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end

            default: begin
               Busy  <= 1'b0;
               Done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_bit_serial_adder
//   Directed, table-driven bench for bit_serial_adder with WIDTH=8, plus
//   hand-written sequences for Start-in-RUN, back-to-back and reset mid-RUN.
//   Define BIT_SERIAL_ADDER_OVF_EN for both files to exercise Ovf.
// ----------------------------------------------------------------------------
module tb_bit_serial_adder;

   localparam int W = 8;

   logic         CLK;
   logic         RST_N;
   logic         Start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Cin;
   logic         Busy;
   logic         Done;
   logic [W-1:0] Sum;
   logic         Cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
   logic         Ovf;
`endif

   int errors = 0;
   int checks = 0;

   bit_serial_adder #(.WIDTH(W)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .Start (Start),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .Busy  (Busy),
      .Done  (Done),
      .Sum   (Sum),
      .Cout  (Cout)
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ,
      .Ovf   (Ovf)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Start at edge k, then expect Busy for edges k..k+7, Done at k+8 and the
   // result held with Done low at k+9. Operands are scrambled after capture.
   task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [W-1:0] es, input logic ec,
                         input logic eo);
      logic bad;
      @(negedge CLK);
      A = a; B = b; Cin = cin; Start = 1'b1;
      @(posedge CLK); #1;
      Start = 1'b0; A = ~a; B = ~b; Cin = ~cin;
      bad = (Busy !== 1'b1) || (Done !== 1'b0);
      for (int i = 1; i < W; i++) begin
         @(posedge CLK); #1;
         if ((Busy !== 1'b1) || (Done !== 1'b0)) bad = 1'b1;
      end
      chk({nm, " busy window"}, 32'(bad), 32'd0);
      @(posedge CLK); #1;
      chk({nm, " done"}, 32'(Done), 32'd1);
      chk({nm, " busy low"}, 32'(Busy), 32'd0);
      chk({nm, " sum"}, 32'(Sum), 32'(es));
      chk({nm, " cout"}, 32'(Cout), 32'(ec));
`ifdef BIT_SERIAL_ADDER_OVF_EN
      chk({nm, " ovf"}, 32'(Ovf), 32'(eo));
`endif
      @(posedge CLK); #1;
      chk({nm, " done strobe"}, 32'(Done), 32'd0);
      chk({nm, " sum held"}, 32'(Sum), 32'(es));
   endtask

   initial begin
      logic bad;
      int   ndone;

      vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[7] = '{8'h3C, 8'h44, 1'b0, 8'h80, 1'b0, 1'b1};

      Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
      RST_N = 1'b1;
      #2 RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset busy", 32'(Busy), 32'd0);
      chk("reset done", 32'(Done), 32'd0);
      chk("reset sum", 32'(Sum), 32'd0);
      chk("reset cout", 32'(Cout), 32'd0);
`ifdef BIT_SERIAL_ADDER_OVF_EN
      chk("reset ovf", 32'(Ovf), 32'd0);
`endif
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (2) @(posedge CLK);

      for (int i = 0; i < 8; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);

      // Start pulsed again while RUN with new operands: ignored.
      @(negedge CLK);
      A = 8'h10; B = 8'h20; Cin = 1'b0; Start = 1'b1;
      @(posedge CLK); #1;                       // edge k
      Start = 1'b0;
      ndone = 0;
      for (int i = 1; i <= 12; i++) begin
         if (i == 3) begin
            @(negedge CLK);
            A = 8'hAA; B = 8'h55; Cin = 1'b1; Start = 1'b1;
         end
         @(posedge CLK); #1;                    // edge k+i
         if (i == 4) Start = 1'b0;
         if (Done === 1'b1) ndone++;
         if (i == W) begin
            chk("run-ignore done", 32'(Done), 32'd1);
            chk("run-ignore sum", 32'(Sum), 32'h30);
            chk("run-ignore cout", 32'(Cout), 32'd0);
         end
      end
      chk("run-ignore done count", 32'(ndone), 32'd1);
      chk("run-ignore idle", 32'(Busy), 32'd0);

      // Back-to-back: Start held high across DONE.
      @(negedge CLK);
      A = 8'h11; B = 8'h22; Cin = 1'b0; Start = 1'b1;
      @(posedge CLK); #1;                       // edge k
      A = 8'h05; B = 8'h03;
      repeat (W) @(posedge CLK);
      #1;                                       // edge k+8
      chk("b2b first done", 32'(Done), 32'd1);
      chk("b2b first sum", 32'(Sum), 32'h33);
      @(posedge CLK); #1;                       // edge k+9: recaptured
      Start = 1'b0;
      chk("b2b done once", 32'(Done), 32'd0);
      chk("b2b busy again", 32'(Busy), 32'd1);
      chk("b2b sum held", 32'(Sum), 32'h33);
      bad = 1'b0;
      for (int i = 1; i < W; i++) begin
         @(posedge CLK); #1;
         if ((Busy !== 1'b1) || (Done !== 1'b0)) bad = 1'b1;
      end
      chk("b2b busy window", 32'(bad), 32'd0);
      @(posedge CLK); #1;                       // edge k+17
      chk("b2b second done", 32'(Done), 32'd1);
      chk("b2b second sum", 32'(Sum), 32'h08);
      @(posedge CLK); #1;
      chk("b2b second strobe", 32'(Done), 32'd0);

      // Leave Sum/Cout non-zero before the reset test.
      run_op("pre-reset", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

      // Reset asserted mid-RUN.
      @(negedge CLK);
      A = 8'h12; B = 8'h34; Cin = 1'b0; Start = 1'b1;
      @(posedge CLK); #1;                       // edge k
      Start = 1'b0;
      repeat (3) @(posedge CLK);
      #1;                                       // after edge k+3
      RST_N = 1'b0;
      #1;
      chk("midrst busy", 32'(Busy), 32'd0);
      chk("midrst done", 32'(Done), 32'd0);
      chk("midrst sum", 32'(Sum), 32'd0);
      chk("midrst cout", 32'(Cout), 32'd0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      ndone = 0;
      for (int i = 0; i < W + 2; i++) begin
         @(posedge CLK); #1;
         if ((Done !== 1'b0) || (Busy !== 1'b0)) ndone++;
      end
      chk("midrst no done", 32'(ndone), 32'd0);
      run_op("post-reset", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
